// File: rtl/pwm_duty_meter_if.sv
// pwm_duty_meter_if: PWM input and measurement result bundle
interface pwm_duty_meter_if #(
  parameter int CNT_W  = 24,
  parameter int DUTY_W = 8
);
  logic              pwm_in;
  logic [DUTY_W-1:0] duty;
  logic [CNT_W-1:0]  period;
  logic              duty_valid;
  logic              timeout;
  logic              overrun;
  modport master (output pwm_in, input duty, period, duty_valid, timeout, overrun);
  modport slave  (input pwm_in, output duty, period, duty_valid, timeout, overrun);
endinterface

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures PWM period and duty with a serial restoring divider
module pwm_duty_meter #(
  parameter int CNT_W  = 24,
  parameter int DUTY_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  pwm_duty_meter_if.slave bus
);
  localparam int SW = $clog2(DUTY_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  typedef enum logic {WAIT_FIRST, MEASURE} state_t;
  state_t state, state_nx;
  logic s1, s, s_d, armed;
  logic [1:0] fill;
  logic [CNT_W-1:0] period_cnt, high_cnt, den, rem;
  logic [DUTY_W-1:0] quo;
  logic [SW-1:0] step;
  logic busy, edge_cyc, cap, tmo, done, start, counting, ge;
  logic [CNT_W:0] rem2;
  // armed blocks a level that is already high at reset release from looking like an edge
  assign edge_cyc = s & ~s_d & armed;
  assign done     = busy && step == SW'(DUTY_W - 1);
  assign start    = cap && (!busy || done);
  assign counting = state == MEASURE && !edge_cyc && !tmo;
  assign rem2     = {rem, 1'b0};
  assign ge       = rem2 >= {1'b0, den};
  assign bus.overrun = cap && busy && !done;
  always_comb begin
    cap      = state == MEASURE && edge_cyc;
    tmo      = state == MEASURE && !edge_cyc && period_cnt == CNT_LAST;
    state_nx = tmo ? WAIT_FIRST : (edge_cyc ? MEASURE : state);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= WAIT_FIRST;
      {s1, s, s_d}   <= '0;
      fill           <= '0;
      armed          <= 1'b0;
      period_cnt     <= '0;
      high_cnt       <= '0;
      den            <= '0;
      rem            <= '0;
      quo            <= '0;
      step           <= '0;
      busy           <= 1'b0;
      bus.duty       <= '0;
      bus.period     <= '0;
      bus.duty_valid <= 1'b0;
      bus.timeout    <= 1'b0;
    end else begin
      s1             <= bus.pwm_in;
      s              <= s1;
      s_d            <= s;
      fill           <= {fill[0], 1'b1};
      armed          <= armed | (fill[1] & ~s);
      state          <= state_nx;
      period_cnt     <= counting ? period_cnt + 1'b1 : '0;
      high_cnt       <= counting ? high_cnt + CNT_W'(s) : '0;
      bus.duty_valid <= 1'b0;
      bus.timeout    <= tmo;
      if (tmo) begin
        busy           <= 1'b0;
        bus.period     <= '1;
        bus.duty       <= s ? '1 : '0;
        bus.duty_valid <= 1'b1;
      end else begin
        if (busy) begin
          rem  <= ge ? CNT_W'(rem2 - {1'b0, den}) : rem2[CNT_W-1:0];
          quo  <= DUTY_W'({quo, ge});
          step <= step + 1'b1;
        end
        if (done) begin
          bus.duty       <= DUTY_W'({quo, ge});
          bus.period     <= den;
          bus.duty_valid <= 1'b1;
          busy           <= 1'b0;
        end
        // the +1 on high accounts for the previous edge cycle, which is always high
        if (start) begin
          rem  <= high_cnt + 1'b1;
          den  <= period_cnt + 1'b1;
          quo  <= '0;
          step <= '0;
          busy <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb_pwm_duty_meter: table-driven PWM stimulus with a result/overrun scoreboard
module tb_pwm_duty_meter;
  localparam int CNT_W  = 16;
  localparam int DUTY_W = 8;
  typedef struct {int high; int low; int reps; int ep; int ed;} vec_t;
  typedef struct {int due; int p; int d; int to;} res_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  res_t sb[$];
  int ovr_q[$];
  bit meas;
  int div_free;
  pwm_duty_meter_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) bus ();
  pwm_duty_meter #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.duty_valid) begin
        if (sb.size() == 0) check("unexpected_valid", 1, 0);
        else begin
          res_t e;
          e = sb.pop_front();
          check("valid_cycle", cyc, e.due);
          check("period", int'(bus.period), e.p);
          check("duty", int'(bus.duty), e.d);
          check("timeout_flag", int'(bus.timeout), e.to);
        end
      end else if (bus.timeout) check("timeout_without_valid", 1, 0);
      if (bus.overrun) begin
        if (ovr_q.size() == 0) check("unexpected_overrun", cyc, -1);
        else check("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end
  // pwm rises at this negedge; the synchronized edge cycle is two cycles later
  task automatic on_rise(int ep, int ed);
    int ec;
    ec = cyc + 2;
    if (!meas) meas = 1'b1;
    else if (ec >= div_free) begin
      sb.push_back('{ec + DUTY_W + 1, ep, ed, 0});
      div_free = ec + DUTY_W;
    end else ovr_q.push_back(ec);
  endtask
  task automatic pulse(int h, int l, int ep, int ed);
    @(negedge clk);
    bus.pwm_in = 1'b1;
    on_rise(ep, ed);
    repeat (h) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask
  task automatic do_reset(logic lvl);
    @(negedge clk);
    reset_n = 1'b0;
    bus.pwm_in = lvl;
    sb.delete();
    ovr_q.delete();
    meas = 1'b0;
    div_free = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic drain(string name);
    repeat (DUTY_W + 14) @(negedge clk);
    check(name, sb.size() + ovr_q.size(), 0);
  endtask
  task automatic check_zero_outputs();
    check("rst_duty", int'(bus.duty), 0);
    check("rst_period", int'(bus.period), 0);
    check("rst_valid", int'(bus.duty_valid), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    check("rst_overrun", int'(bus.overrun), 0);
  endtask
  initial begin
    vec_t tbl[8];
    tbl[0] = '{3, 7, 5, 10, 76};
    tbl[1] = '{1, 255, 3, 256, 1};
    tbl[2] = '{255, 1, 3, 256, 255};
    tbl[3] = '{2, 2, 9, 4, 128};
    tbl[4] = '{5, 11, 4, 16, 80};
    tbl[5] = '{7, 13, 4, 20, 89};
    tbl[6] = '{1, 9, 4, 10, 25};
    tbl[7] = '{9, 1, 4, 10, 230};
    bus.pwm_in = 1'b0;
    meas = 1'b0;
    div_free = 0;
    #1 check_zero_outputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    foreach (tbl[i]) begin
      do_reset(1'b0);
      repeat (tbl[i].reps) pulse(tbl[i].high, tbl[i].low, tbl[i].ep, tbl[i].ed);
      drain("vector_drain");
    end
    // level already high at reset release must not count as an edge
    do_reset(1'b1);
    repeat (20) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (6) @(negedge clk);
    repeat (3) pulse(1, 9, 10, 25);
    drain("high_at_release_drain");
    // reset pulse while a division is in flight
    do_reset(1'b0);
    repeat (2) pulse(3, 7, 10, 76);
    @(negedge clk);
    bus.pwm_in = 1'b1;
    on_rise(10, 76);
    repeat (3) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_reset_duty", int'(bus.duty), 76);
    check("pending_before_reset", sb.size(), 1);
    reset_n = 1'b0;
    #1 check_zero_outputs();
    sb.delete();
    meas = 1'b0;
    div_free = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    repeat (3) pulse(3, 7, 10, 76);
    drain("post_reset_drain");
    // no-edge timeout with pwm held high, then the next edge only re-arms
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.pwm_in = 1'b1;
    on_rise(0, 0);
    sb.push_back('{cyc + 2 + 65536, 65535, 255, 1});
    meas = 1'b0;
    repeat (70000) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    bus.pwm_in = 1'b1;
    on_rise(0, 0);
    repeat (5) @(negedge clk);
    bus.pwm_in = 1'b0;
    drain("timeout_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
